// File: rtl/atb_trace_replicator.sv
// ATB trace replicator: fans one aggregated ATB stream out to NUM_OUT sinks,
// with per-sink ATID match/mask filtering decided once per packet.
module atb_trace_replicator #(
  parameter int NUM_OUT    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ATID_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [NUM_OUT-1:0]            out_en_i,
  input  logic [NUM_OUT*ATID_WIDTH-1:0] id_match_i,
  input  logic [NUM_OUT*ATID_WIDTH-1:0] id_mask_i,
  input  logic [ATID_WIDTH-1:0]         s_atid_i,
  input  logic                          s_atvalid_i,
  input  logic [DATA_WIDTH-1:0]         s_atdata_i,
  input  logic                          s_atlast_i,
  output logic                          s_atready_o,
  output logic [ATID_WIDTH-1:0]         m_atid_o,
  output logic [DATA_WIDTH-1:0]         m_atdata_o,
  output logic                          m_atlast_o,
  output logic [NUM_OUT-1:0]            m_atvalid_o,
  input  logic [NUM_OUT-1:0]            m_atready_i,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o,
  output logic                          busy_o
);

  typedef enum logic {
    IDLE,
    PKT
  } state_e;

  state_e                  state_q;
  logic                    live_q;
  logic                    hold_v_q;
  logic [ATID_WIDTH-1:0]   hold_id_q;
  logic [DATA_WIDTH-1:0]   hold_data_q;
  logic                    hold_last_q;
  logic [NUM_OUT-1:0]      tgt_q;
  logic [NUM_OUT-1:0]      sent_q;
  logic [NUM_OUT-1:0]      pkt_tgt_q;
  logic [CNT_WIDTH-1:0]    drop_cnt_q;

  logic [NUM_OUT-1:0]      hit;
  logic [NUM_OUT-1:0]      beat_tgt;
  logic [NUM_OUT-1:0]      fire;
  logic                    done;
  logic                    accept;
  logic                    load;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      hit[k] = out_en_i[k] && (s_atid_i != '0) &&
               (((s_atid_i ^ id_match_i[k*ATID_WIDTH +: ATID_WIDTH]) &
                 id_mask_i[k*ATID_WIDTH +: ATID_WIDTH]) == '0);
    end
  end

  // Inside a packet the routing latched at its first beat wins over the live filter.
  assign beat_tgt    = (state_q == PKT) ? pkt_tgt_q : hit;
  assign m_atvalid_o = {NUM_OUT{hold_v_q}} & tgt_q & ~sent_q;
  assign fire        = m_atvalid_o & m_atready_i;
  assign done        = hold_v_q && (((sent_q | fire) & tgt_q) == tgt_q);
  // live_q keeps ready low while in reset even if enable_i is already high.
  assign s_atready_o = live_q & enable_i & (~hold_v_q | done);
  assign accept      = s_atvalid_i & s_atready_o;
  assign load        = accept & (|beat_tgt);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the data register is reset too, since m_atdata_o must read 0 after reset.
      state_q     <= IDLE;
      live_q      <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_id_q   <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      tgt_q       <= '0;
      sent_q      <= '0;
      pkt_tgt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      live_q <= 1'b1;

      if (load) begin
        hold_v_q    <= 1'b1;
        hold_id_q   <= s_atid_i;
        hold_data_q <= s_atdata_i;
        hold_last_q <= s_atlast_i;
        tgt_q       <= beat_tgt;
      end else if (done) begin
        hold_v_q    <= 1'b0;
      end

      sent_q <= done ? '0 : (sent_q | fire);

      if (accept && !load && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end

      if (!enable_i) begin
        state_q <= IDLE;
      end else if (accept) begin
        if (state_q == IDLE) begin
          if (!s_atlast_i) begin
            state_q   <= PKT;
            pkt_tgt_q <= hit;
          end
        end else if (s_atlast_i) begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign m_atid_o   = hold_id_q;
  assign m_atdata_o = hold_data_q;
  assign m_atlast_o = hold_last_q;
  assign drop_cnt_o = drop_cnt_q;
  assign busy_o     = hold_v_q | (state_q == PKT);

endmodule

// File: tb/tb_atb_trace_replicator.sv
// Directed self-checking bench for atb_trace_replicator (NUM_OUT=2, default widths).
module tb_atb_trace_replicator;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int IW = 8;
  localparam int CW = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            enable_i;
  logic [N-1:0]    out_en_i;
  logic [N*IW-1:0] id_match_i;
  logic [N*IW-1:0] id_mask_i;
  logic [IW-1:0]   s_atid_i;
  logic            s_atvalid_i;
  logic [DW-1:0]   s_atdata_i;
  logic            s_atlast_i;
  logic            s_atready_o;
  logic [IW-1:0]   m_atid_o;
  logic [DW-1:0]   m_atdata_o;
  logic            m_atlast_o;
  logic [N-1:0]    m_atvalid_o;
  logic [N-1:0]    m_atready_i;
  logic [CW-1:0]   drop_cnt_o;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  atb_trace_replicator #(
    .NUM_OUT(N), .DATA_WIDTH(DW), .ATID_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .out_en_i(out_en_i),
    .id_match_i(id_match_i), .id_mask_i(id_mask_i), .s_atid_i(s_atid_i),
    .s_atvalid_i(s_atvalid_i), .s_atdata_i(s_atdata_i), .s_atlast_i(s_atlast_i),
    .s_atready_o(s_atready_o), .m_atid_o(m_atid_o), .m_atdata_o(m_atdata_o),
    .m_atlast_o(m_atlast_o), .m_atvalid_o(m_atvalid_o), .m_atready_i(m_atready_i),
    .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic beat(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic l);
    s_atvalid_i = 1'b1;
    s_atid_i    = id;
    s_atdata_i  = d;
    s_atlast_i  = l;
    #1;
  endtask

  task automatic idle_in();
    s_atvalid_i = 1'b0;
    s_atlast_i  = 1'b0;
    #1;
  endtask

  logic any_valid;

  initial begin
    rst_ni      = 1'b0;
    enable_i    = 1'b1;
    out_en_i    = 2'b11;
    id_match_i  = '0;
    id_mask_i   = '0;
    s_atid_i    = '0;
    s_atvalid_i = 1'b0;
    s_atdata_i  = '0;
    s_atlast_i  = 1'b0;
    m_atready_i = 2'b11;

    #12;
    check("rst_ready", s_atready_o, 0);
    check("rst_valid", m_atvalid_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    step();

    // Three-beat packet to both sinks at full rate
    beat(8'h05, 64'hA, 1'b0);
    check("t1_rdy_a", s_atready_o, 1);
    step();
    check("t1_valid_a", m_atvalid_o, 2'b11);
    check("t1_data_a", m_atdata_o, 64'hA);
    check("t1_busy", busy_o, 1);
    beat(8'h05, 64'hB, 1'b0);
    check("t1_rdy_b", s_atready_o, 1);
    step();
    check("t1_data_b", m_atdata_o, 64'hB);
    check("t1_valid_b", m_atvalid_o, 2'b11);
    beat(8'h05, 64'hC, 1'b1);
    check("t1_rdy_c", s_atready_o, 1);
    step();
    check("t1_data_c", m_atdata_o, 64'hC);
    check("t1_last_c", m_atlast_o, 1);
    check("t1_valid_c", m_atvalid_o, 2'b11);
    idle_in();
    step();
    check("t1_drained", m_atvalid_o, 0);
    check("t1_idle", busy_o, 0);

    // Sink1 stalls three cycles on beat A
    m_atready_i = 2'b01;
    beat(8'h05, 64'hA2, 1'b0);
    step();
    check("t2_valid_c1", m_atvalid_o, 2'b11);
    check("t2_data_a", m_atdata_o, 64'hA2);
    beat(8'h05, 64'hB2, 1'b1);
    check("t2_rdy_c1", s_atready_o, 0);
    step();
    check("t2_no_repeat_c2", m_atvalid_o, 2'b10);
    check("t2_rdy_c2", s_atready_o, 0);
    step();
    check("t2_no_repeat_c3", m_atvalid_o, 2'b10);
    check("t2_hold_a", m_atdata_o, 64'hA2);
    m_atready_i = 2'b11;
    #1;
    check("t2_rdy_release", s_atready_o, 1);
    step();
    check("t2_data_b", m_atdata_o, 64'hB2);
    check("t2_valid_b", m_atvalid_o, 2'b11);
    idle_in();
    step();
    check("t2_drained", m_atvalid_o, 0);

    // Per-sink ATID filtering and drop counting
    id_match_i = {8'h20, 8'h10};
    id_mask_i  = {8'hF0, 8'hF0};
    beat(8'h13, 64'h13, 1'b1);
    step();
    check("t3_id13", m_atvalid_o, 2'b01);
    beat(8'h25, 64'h25, 1'b1);
    step();
    check("t3_id25", m_atvalid_o, 2'b10);
    check("t3_data25", m_atdata_o, 64'h25);
    beat(8'h35, 64'h35, 1'b1);
    check("t3_rdy35", s_atready_o, 1);
    step();
    check("t3_id35", m_atvalid_o, 2'b00);
    check("t3_drop", drop_cnt_o, 1);
    idle_in();

    // Filter change mid-packet is ignored until the packet ends
    id_match_i = {8'h10, 8'h10};
    beat(8'h13, 64'h41, 1'b0);
    step();
    check("t4_b1", m_atvalid_o, 2'b11);
    beat(8'h13, 64'h42, 1'b0);
    id_match_i = {8'h20, 8'h10};
    #1;
    step();
    check("t4_b2", m_atvalid_o, 2'b11);
    check("t4_b2_data", m_atdata_o, 64'h42);
    beat(8'h13, 64'h43, 1'b0);
    step();
    check("t4_b3", m_atvalid_o, 2'b11);
    check("t4_b3_data", m_atdata_o, 64'h43);
    beat(8'h13, 64'h44, 1'b1);
    step();
    check("t4_b4", m_atvalid_o, 2'b11);
    check("t4_b4_data", m_atdata_o, 64'h44);
    beat(8'h13, 64'h50, 1'b1);
    step();
    check("t4_next_excluded", m_atvalid_o, 2'b01);
    check("t4_next_data", m_atdata_o, 64'h50);
    idle_in();
    step();
    check("t4_idle", busy_o, 0);

    enable_i = 1'b0;
    #1;
    check("en_off_rdy", s_atready_o, 0);
    enable_i = 1'b1;
    #1;

    // Null-ATID flood saturates the drop counter
    beat(8'h00, 64'h0, 1'b1);
    any_valid = 1'b0;
    repeat (65536) begin
      step();
      if (m_atvalid_o != '0) any_valid = 1'b1;
    end
    check("t5_drop_sat", drop_cnt_o, 16'hFFFF);
    check("t5_no_valid", any_valid, 0);
    idle_in();

    // Async reset mid-packet with the hold stage full
    id_match_i  = {8'h10, 8'h10};
    m_atready_i = 2'b00;
    beat(8'h13, 64'h61, 1'b0);
    step();
    check("t6_full_valid", m_atvalid_o, 2'b11);
    check("t6_full_busy", busy_o, 1);
    idle_in();
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", m_atvalid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_drop", drop_cnt_o, 0);
    step();
    @(negedge clk_i) rst_ni = 1'b1;
    m_atready_i = 2'b11;
    id_match_i  = {8'h20, 8'h10};
    step();
    check("t6_post_busy", busy_o, 0);
    check("t6_post_rdy", s_atready_o, 1);
    beat(8'h25, 64'h62, 1'b1);
    step();
    check("t6_new_pkt", m_atvalid_o, 2'b10);
    check("t6_new_data", m_atdata_o, 64'h62);
    idle_in();
    step();
    check("t6_drained", m_atvalid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
